seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Downstream display stage of the keypad/display panel. Takes the 40-bit, 5-digit segment image
//  (data_out) and display mode (seg_mode) from the panel interface FSM. Time-multiplexes the image
//  onto a 5-digit common-cathode 7-segment display, with inter-digit ghost blanking and blink.
//  Returns flash_cnt, the completed-blink count the interface FSM uses to time its startup splash.
// PARAMETERS
//  DIG_DIV     20000  clk cycles per digit slot (1 kHz/digit at 20 MHz, 200 Hz frame)
//  BLANK_CYC   40     clk cycles at start of each slot with all digits off (anti-ghost); < DIG_DIV
//  FLASH_SLOTS 250    digit slots per blink half-period (250 ms at defaults)
// PORTS
//  clk          in   1   panel clock, 20 MHz
//  reset        in   1   asynchronous, active-low
//  data_in      in   40  digit image: [39:32]=digit0 (leftmost) .. [7:0]=digit4; per byte bit7=dp, [6:0]=g..a
//  seg_mode     in   3   3'd0 constant, 3'd1 flash all, 3'd2 flash digit, 3'd3 blank; others = constant
//  blink_digit  in   3   digit index 0..4 blinked in mode 3'd2; values 5..7 blink nothing
//  dig_sel      out  5   digit enables, active-low, one-hot-low; bit i drives digit i
//  seg_out      out  8   segment drive, active-high, same bit map as data_in bytes
//  flash_cnt    out  3   completed blink periods since entering a flash mode, saturates at 7
//  frame_start  out  1   1-cycle pulse when digit 0 slot begins (shadow load instant)
// BEHAVIOUR
//  Reset (async assert, sync release): dig_sel=5'b11111, seg_out=8'h00, flash_cnt=0, frame_start=0,
//   digit index=0, slot counter=0, blink phase=ON, blink timer=0, shadow image=40'h0.
//  Slot counter 0..DIG_DIV-1 wraps; at wrap the digit index advances 0->1->2->3->4->0.
//  Per-slot phases: BLANK (count < BLANK_CYC): dig_sel=5'b11111, seg_out=8'h00.
//   DRIVE (otherwise): dig_sel bit[idx]=0, seg_out = shadow byte for idx, or 8'h00 if suppressed.
//  Outputs are registered: a count change shows on dig_sel/seg_out on the next clk edge.
//  Shadow load: data_in copied to shadow on the clk where idx wraps 4->0 (and on the first cycle
//   after reset); frame_start pulses that same cycle. Mid-frame data_in changes appear next frame.
//  Suppression: mode 3'd3 -> all digits suppressed (dig_sel still scans, seg_out=0).
//   Mode 3'd1 -> all digits suppressed while blink phase=OFF.
//   Mode 3'd2 -> only digit blink_digit suppressed while phase=OFF; blink_digit>4 suppresses none.
//  Blink timer counts slot wraps 0..FLASH_SLOTS-1; at terminal count the phase toggles.
//   OFF->ON toggle completes one period: flash_cnt += 1, saturating at 3'd7.
//  Blink timer/phase/flash_cnt run only in modes 3'd1/3'd2. Any other mode holds them at
//   timer=0, phase=ON, flash_cnt=0. Mode change between 3'd1 and 3'd2 is treated as a fresh entry
//   (same reset), so the first period is always full length.
//  seg_mode and blink_digit are sampled every clk (not shadowed). Suppression takes effect next cycle.
//  Reset asserted mid-slot: outputs go to reset values immediately. Scan restarts at digit 0 after release.
// CONFIGURATION
//  SEG_DIMMING_EN defined: adds input brightness[2:0]. In DRIVE, segments are on only while
//   (count-BLANK_CYC) < ((DIG_DIV-BLANK_CYC)*(brightness+1))>>3; beyond that, dig_sel=5'b11111 and seg_out=0.
//   brightness=7 equals full drive. brightness sampled at slot start.
//  Not defined: no brightness port; digit driven for the whole DRIVE phase.
// TESTING  (DIG_DIV=20, BLANK_CYC=4, FLASH_SLOTS=3 for sim)
//  1 reset low 5 cyc, data_in=40'h3F_06_5B_4F_66, mode 0 -> dig_sel 11110/seg 3F, then 11101/06 ...
//    11111 each slot's first 4 cyc. frame_start every 100 cyc.
//  2 change data_in to all 8'h7F at slot 2 -> digits 2..4 keep old bytes. 7F on all from next frame_start.
//  3 mode 1 -> seg_out 0 for slots 3..5 after entry, ON 6..8. flash_cnt 1 after slot 6, ... saturates at 7,
//    mode 0 -> flash_cnt 0 next cyc.
//  4 mode 2, blink_digit=2 -> only digit 2 blanks in OFF phase. blink_digit=6 -> no digit ever blanks.
//  5 assert reset mid-DRIVE of digit 3 -> same-cycle dig_sel=11111, seg 00. After release, scan resumes at digit 0.
//  6 SEG_DIMMING_EN, brightness=1 -> per slot 4 cyc drive, 12 cyc off. brightness=7 -> 16 cyc drive.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// Link between the panel interface FSM and the segment scan driver.
// SEG_DIMMING_EN adds the brightness field.
interface seg_scan_driver_if;
   logic [39:0] data_in;
   logic [2:0]  seg_mode;
   logic [2:0]  blink_digit;
   logic [2:0]  flash_cnt;
   logic        frame_start;
`ifdef SEG_DIMMING_EN
   logic [2:0]  brightness;

   modport master (output data_in, seg_mode, blink_digit, brightness,
                   input  flash_cnt, frame_start);
   modport slave  (input  data_in, seg_mode, blink_digit, brightness,
                   output flash_cnt, frame_start);
`else
   modport master (output data_in, seg_mode, blink_digit,
                   input  flash_cnt, frame_start);
   modport slave  (input  data_in, seg_mode, blink_digit,
                   output flash_cnt, frame_start);
`endif
endinterface

// File: rtl/seg_scan_driver.sv
// 5-digit common-cathode 7-segment scanner with anti-ghost blanking, blink and blink counting.
// Optional feature macro: SEG_DIMMING_EN (per-slot PWM brightness).
module seg_scan_driver #(
   parameter int unsigned DIG_DIV     = 20000,
   parameter int unsigned BLANK_CYC   = 40,
   parameter int unsigned FLASH_SLOTS = 250
) (
   input  logic             clk,
   input  logic             reset,
   seg_scan_driver_if.slave pif,
   output logic [4:0]       dig_sel,
   output logic [7:0]       seg_out
);
   localparam int unsigned CNT_W    = (DIG_DIV > 1) ? $clog2(DIG_DIV) : 1;
   localparam int unsigned TMR_W    = (FLASH_SLOTS > 1) ? $clog2(FLASH_SLOTS) : 1;
   localparam int unsigned IDX_W    = 3;
   localparam int unsigned LAST_DIG = 4;

   typedef enum logic {PH_ON = 1'b0, PH_OFF = 1'b1} phase_e;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             first_q, first_d;
   logic [39:0]      shadow_q, shadow_d;
   phase_e           phase_q, phase_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [2:0]       fcnt_q, fcnt_d;
   logic [2:0]       mode_q, mode_d;
   logic [4:0]       dig_q, dig_d;
   logic [7:0]       seg_q, seg_d;
   logic             fstart_q, fstart_d;
`ifdef SEG_DIMMING_EN
   logic [2:0]       bright_q, bright_d;
   logic [31:0]      on_len_c;
`endif
   logic             slot_end_c, flashing_c, suppress_c, drive_c;
   logic [7:0]       byte_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         first_q  <= 1'b1;
         shadow_q <= '0;
         phase_q  <= PH_ON;
         tmr_q    <= '0;
         fcnt_q   <= '0;
         mode_q   <= '0;
         dig_q    <= 5'b11111;
         seg_q    <= 8'h00;
         fstart_q <= 1'b0;
`ifdef SEG_DIMMING_EN
         bright_q <= 3'd7;
`endif
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         first_q  <= first_d;
         shadow_q <= shadow_d;
         phase_q  <= phase_d;
         tmr_q    <= tmr_d;
         fcnt_q   <= fcnt_d;
         mode_q   <= mode_d;
         dig_q    <= dig_d;
         seg_q    <= seg_d;
         fstart_q <= fstart_d;
`ifdef SEG_DIMMING_EN
         bright_q <= bright_d;
`endif
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      first_d    = first_q;
      shadow_d   = shadow_q;
      phase_d    = phase_q;
      tmr_d      = tmr_q;
      fcnt_d     = fcnt_q;
      mode_d     = pif.seg_mode;
      fstart_d   = 1'b0;
      dig_d      = 5'b11111;
      seg_d      = 8'h00;
      suppress_c = 1'b0;
      byte_c     = 8'h00;
`ifdef SEG_DIMMING_EN
      bright_d   = bright_q;
`endif
      slot_end_c = (cnt_q == CNT_W'(DIG_DIV - 1));
      flashing_c = (pif.seg_mode == 3'd1) || (pif.seg_mode == 3'd2);

      // Scan position; the first cycle out of reset is a frame boundary held at digit 0, count 0
      if (first_q) begin
         first_d  = 1'b0;
         shadow_d = pif.data_in;
         fstart_d = 1'b1;
`ifdef SEG_DIMMING_EN
         bright_d = pif.brightness;
`endif
      end else if (slot_end_c) begin
         cnt_d = '0;
         if (idx_q == IDX_W'(LAST_DIG)) begin
            idx_d    = '0;
            shadow_d = pif.data_in;
            fstart_d = 1'b1;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
`ifdef SEG_DIMMING_EN
         bright_d = pif.brightness;
`endif
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // Blink runs only while flashing; a mode change restarts it so the first period is full
      if (!flashing_c || (pif.seg_mode != mode_q)) begin
         tmr_d   = '0;
         phase_d = PH_ON;
         fcnt_d  = '0;
      end else if (slot_end_c && !first_q) begin
         if (tmr_q == TMR_W'(FLASH_SLOTS - 1)) begin
            tmr_d   = '0;
            phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
            if ((phase_q == PH_OFF) && (fcnt_q != 3'd7)) begin
               fcnt_d = fcnt_q + 3'd1;
            end
         end else begin
            tmr_d = tmr_q + TMR_W'(1);
         end
      end

      case (idx_q)
         3'd0:    byte_c = shadow_q[39:32];
         3'd1:    byte_c = shadow_q[31:24];
         3'd2:    byte_c = shadow_q[23:16];
         3'd3:    byte_c = shadow_q[15:8];
         3'd4:    byte_c = shadow_q[7:0];
         default: byte_c = 8'h00;
      endcase

      case (pif.seg_mode)
         3'd1:    suppress_c = (phase_q == PH_OFF);
         3'd2:    suppress_c = (phase_q == PH_OFF) && (pif.blink_digit == idx_q);
         3'd3:    suppress_c = 1'b1;
         default: suppress_c = 1'b0;
      endcase

      drive_c = (cnt_q >= CNT_W'(BLANK_CYC));
`ifdef SEG_DIMMING_EN
      on_len_c = ((DIG_DIV - BLANK_CYC) * (32'(bright_q) + 32'd1)) >> 3;
      drive_c  = drive_c && ((32'(cnt_q) - BLANK_CYC) < on_len_c);
`endif

      if (drive_c) begin
         dig_d = ~(5'b00001 << idx_q);
         seg_d = suppress_c ? 8'h00 : byte_c;
      end
   end

   assign dig_sel         = dig_q;
   assign seg_out         = seg_q;
   assign pif.flash_cnt   = fcnt_q;
   assign pif.frame_start = fstart_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a cycle-position reference model.
module tb_seg_scan_driver;
   localparam int unsigned DIG_DIV     = 20;
   localparam int unsigned BLANK_CYC   = 4;
   localparam int unsigned FLASH_SLOTS = 3;
   localparam int unsigned FRAME       = 5 * DIG_DIV;

   logic       clk;
   logic       reset;
   logic [4:0] dig_sel;
   logic [7:0] seg_out;

   seg_scan_driver_if pif ();

   seg_scan_driver #(
      .DIG_DIV    (DIG_DIV),
      .BLANK_CYC  (BLANK_CYC),
      .FLASH_SLOTS(FLASH_SLOTS)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .pif    (pif),
      .dig_sel(dig_sel),
      .seg_out(seg_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: absolute scan position within the frame plus blink bookkeeping
   bit         m_started;
   int         m_pos;
   logic [7:0] m_shadow [5];
   bit         m_on;
   int         m_slots;
   int         m_fc;
   logic [2:0] m_prev;
   int         m_bright;
   logic [4:0] e_dig;
   logic [7:0] e_seg;
   logic       e_fs;

   task automatic model_reset();
      m_started = 1'b0;
      m_pos     = 0;
      m_on      = 1'b1;
      m_slots   = 0;
      m_fc      = 0;
      m_prev    = 3'd0;
      m_bright  = 7;
      e_dig     = 5'h1F;
      e_seg     = 8'h00;
      e_fs      = 1'b0;
      for (int k = 0; k < 5; k++) m_shadow[k] = 8'h00;
   endtask

   task automatic load_shadow();
      for (int k = 0; k < 5; k++) m_shadow[k] = pif.data_in[8*(4-k) +: 8];
   endtask

   function automatic int bright_in();
`ifdef SEG_DIMMING_EN
      return int'(pif.brightness);
`else
      return 7;
`endif
   endfunction

   // Advance one clock: outputs after the edge reflect the position held before it
   task automatic step();
      int c, i;
      bit drive, supp, last;
      int mode;
      @(posedge clk);
      mode  = int'(pif.seg_mode);
      c     = m_pos % DIG_DIV;
      i     = m_pos / DIG_DIV;
      drive = (c >= int'(BLANK_CYC));
      if (drive && ((c - int'(BLANK_CYC)) >= (int'(DIG_DIV - BLANK_CYC) * (m_bright + 1)) / 8))
         drive = 1'b0;
      case (mode)
         1:       supp = !m_on;
         2:       supp = !m_on && (int'(pif.blink_digit) == i);
         3:       supp = 1'b1;
         default: supp = 1'b0;
      endcase
      e_dig = drive ? ~(5'b00001 << i) : 5'h1F;
      e_seg = (drive && !supp) ? m_shadow[i] : 8'h00;

      last = 1'b0;
      e_fs = 1'b0;
      if (!m_started) begin
         m_started = 1'b1;
         load_shadow();
         e_fs     = 1'b1;
         m_bright = bright_in();
      end else begin
         last  = (c == int'(DIG_DIV) - 1);
         m_pos = (m_pos + 1) % FRAME;
         if (m_pos == 0) begin
            load_shadow();
            e_fs = 1'b1;
         end
         if (last) m_bright = bright_in();
      end

      if (!(mode == 1 || mode == 2) || (pif.seg_mode != m_prev)) begin
         m_slots = 0;
         m_on    = 1'b1;
         m_fc    = 0;
      end else if (last) begin
         m_slots++;
         if (m_slots == FLASH_SLOTS) begin
            m_slots = 0;
            if (!m_on && m_fc < 7) m_fc++;
            m_on = !m_on;
         end
      end
      m_prev = pif.seg_mode;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset           = 1'b0;
      pif.data_in     = 40'h3F_06_5B_4F_66;
      pif.seg_mode    = 3'd0;
      pif.blink_digit = 3'd7;
`ifdef SEG_DIMMING_EN
      pif.brightness  = 3'd7;
`endif
      model_reset();
      repeat (5) @(negedge clk);
      n_checks++; if (dig_sel !== 5'h1F) begin n_errors++; $display("FAIL reset.dig_sel got %b want 11111", dig_sel); end
      n_checks++; if (seg_out !== 8'h00) begin n_errors++; $display("FAIL reset.seg_out got %h want 00", seg_out); end
      n_checks++; if (pif.flash_cnt !== 3'd0) begin n_errors++; $display("FAIL reset.flash_cnt got %0d want 0", pif.flash_cnt); end
      n_checks++; if (pif.frame_start !== 1'b0) begin n_errors++; $display("FAIL reset.frame_start got %b want 0", pif.frame_start); end
      reset = 1'b1;
   endtask

   task automatic test_scan();
      for (int k = 1; k <= 220; k++) begin
         step();
         n_checks++; if (dig_sel !== e_dig) begin n_errors++; $display("FAIL scan.dig_sel cyc %0d got %b want %b", k, dig_sel, e_dig); end
         n_checks++; if (seg_out !== e_seg) begin n_errors++; $display("FAIL scan.seg_out cyc %0d got %h want %h", k, seg_out, e_seg); end
         n_checks++; if (pif.frame_start !== e_fs) begin n_errors++; $display("FAIL scan.frame_start cyc %0d got %b want %b", k, pif.frame_start, e_fs); end
         if (k == 5) begin
            n_checks++; if (dig_sel !== 5'h1F) begin n_errors++; $display("FAIL scan.blank0 got %b want 11111", dig_sel); end
         end
         if (k == 6) begin
            n_checks++; if (dig_sel !== 5'b11110 || seg_out !== 8'h3F) begin n_errors++; $display("FAIL scan.digit0 got %b/%h want 11110/3f", dig_sel, seg_out); end
         end
         if (k == 26) begin
            n_checks++; if (dig_sel !== 5'b11101 || seg_out !== 8'h06) begin n_errors++; $display("FAIL scan.digit1 got %b/%h want 11101/06", dig_sel, seg_out); end
         end
         if (k == 101) begin
            n_checks++; if (pif.frame_start !== 1'b1) begin n_errors++; $display("FAIL scan.frame_period got %b want 1", pif.frame_start); end
         end
      end
   endtask

   task automatic test_midframe();
      int guard = 0;
      while (m_pos != int'(2 * DIG_DIV) + 5 && guard < 200) begin step(); guard++; end
      n_checks++; if (guard >= 200) begin n_errors++; $display("FAIL midframe.sync got timeout want slot 2"); end
      pif.data_in = 40'h7F_7F_7F_7F_7F;
      for (int k = 0; k < 200; k++) begin
         step();
         n_checks++; if (dig_sel !== e_dig) begin n_errors++; $display("FAIL midframe.dig_sel cyc %0d got %b want %b", k, dig_sel, e_dig); end
         n_checks++; if (seg_out !== e_seg) begin n_errors++; $display("FAIL midframe.seg_out cyc %0d got %h want %h", k, seg_out, e_seg); end
         n_checks++; if (pif.frame_start !== e_fs) begin n_errors++; $display("FAIL midframe.frame_start cyc %0d got %b want %b", k, pif.frame_start, e_fs); end
      end
   endtask

   task automatic test_flash_all();
      pif.data_in  = {$urandom(), 8'($urandom())};
      pif.seg_mode = 3'd1;
      for (int k = 0; k < 900; k++) begin
         step();
         n_checks++; if (dig_sel !== e_dig) begin n_errors++; $display("FAIL flash_all.dig_sel cyc %0d got %b want %b", k, dig_sel, e_dig); end
         n_checks++; if (seg_out !== e_seg) begin n_errors++; $display("FAIL flash_all.seg_out cyc %0d got %h want %h", k, seg_out, e_seg); end
         n_checks++; if (pif.flash_cnt !== 3'(m_fc)) begin n_errors++; $display("FAIL flash_all.flash_cnt cyc %0d got %0d want %0d", k, pif.flash_cnt, m_fc); end
      end
      n_checks++; if (pif.flash_cnt !== 3'd7) begin n_errors++; $display("FAIL flash_all.saturate got %0d want 7", pif.flash_cnt); end
      pif.seg_mode = 3'd0;
      step();
      n_checks++; if (pif.flash_cnt !== 3'd0) begin n_errors++; $display("FAIL flash_all.clear got %0d want 0", pif.flash_cnt); end
   endtask

   task automatic test_flash_digit();
      pif.seg_mode    = 3'd2;
      pif.blink_digit = 3'd2;
      for (int k = 0; k < 700; k++) begin
         if (k == 300) pif.blink_digit = 3'd6;
         step();
         n_checks++; if (dig_sel !== e_dig) begin n_errors++; $display("FAIL flash_digit.dig_sel cyc %0d got %b want %b", k, dig_sel, e_dig); end
         n_checks++; if (seg_out !== e_seg) begin n_errors++; $display("FAIL flash_digit.seg_out cyc %0d got %h want %h", k, seg_out, e_seg); end
         n_checks++; if (pif.flash_cnt !== 3'(m_fc)) begin n_errors++; $display("FAIL flash_digit.flash_cnt cyc %0d got %0d want %0d", k, pif.flash_cnt, m_fc); end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 59) == 0) pif.seg_mode = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
         if ($urandom_range(0, 79) == 0) pif.blink_digit = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 29) == 0) pif.data_in = {$urandom(), 8'($urandom())};
         step();
         n_checks++; if (dig_sel !== e_dig) begin n_errors++; $display("FAIL random.dig_sel cyc %0d got %b want %b", k, dig_sel, e_dig); end
         n_checks++; if (seg_out !== e_seg) begin n_errors++; $display("FAIL random.seg_out cyc %0d got %h want %h", k, seg_out, e_seg); end
         n_checks++; if (pif.flash_cnt !== 3'(m_fc)) begin n_errors++; $display("FAIL random.flash_cnt cyc %0d got %0d want %0d", k, pif.flash_cnt, m_fc); end
         n_checks++; if (pif.frame_start !== e_fs) begin n_errors++; $display("FAIL random.frame_start cyc %0d got %b want %b", k, pif.frame_start, e_fs); end
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      pif.seg_mode = 3'd0;
      while (!(e_dig == 5'b10111 && (m_pos % DIG_DIV) == 10) && guard < 300) begin step(); guard++; end
      n_checks++; if (guard >= 300 || dig_sel !== 5'b10111) begin n_errors++; $display("FAIL reset_mid.sync got %b want 10111", dig_sel); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (dig_sel !== 5'h1F) begin n_errors++; $display("FAIL reset_mid.dig_sel got %b want 11111", dig_sel); end
      n_checks++; if (seg_out !== 8'h00) begin n_errors++; $display("FAIL reset_mid.seg_out got %h want 00", seg_out); end
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         step();
         n_checks++; if (dig_sel !== e_dig) begin n_errors++; $display("FAIL reset_mid.resume_dig cyc %0d got %b want %b", k, dig_sel, e_dig); end
         n_checks++; if (seg_out !== e_seg) begin n_errors++; $display("FAIL reset_mid.resume_seg cyc %0d got %h want %h", k, seg_out, e_seg); end
         if (k == 6) begin
            n_checks++; if (dig_sel !== 5'b11110) begin n_errors++; $display("FAIL reset_mid.digit0 got %b want 11110", dig_sel); end
         end
      end
   endtask

`ifdef SEG_DIMMING_EN
   task automatic test_dimming();
      pif.seg_mode = 3'd0;
      for (int k = 0; k < 400; k++) begin
         if (k == 0)   pif.brightness = 3'd1;
         if (k == 200) pif.brightness = 3'd7;
         step();
         n_checks++; if (dig_sel !== e_dig) begin n_errors++; $display("FAIL dimming.dig_sel cyc %0d got %b want %b", k, dig_sel, e_dig); end
         n_checks++; if (seg_out !== e_seg) begin n_errors++; $display("FAIL dimming.seg_out cyc %0d got %h want %h", k, seg_out, e_seg); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan();
      test_midframe();
      test_flash_all();
      test_flash_digit();
      test_random();
      test_reset_mid();
`ifdef SEG_DIMMING_EN
      test_dimming();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
